mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter in front of the shared multi-cycle main memory. Accepts block-fill requests from the I-cache and D-cache fill FSMs plus single-word write-through stores from the D-cache. Grants exactly one owner at a time, drives the memory request lines, and steers returning `memory_data_valid` beats to the owner. It generates the `waitForICACHE` arbitration signal consumed by the D-cache fill FSM.

## Interface
- `TIMEOUT`, default 64: maximum cycles a fill grant may be held before the watchdog fires. Used only with `ARB_TIMEOUT_EN`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `i_busy` in 1: I-cache fill FSM `fsm_busy`; acts as the fill request.
- `i_addr` in 16: I-cache fill FSM `memory_address`.
- `d_busy` in 1: D-cache fill FSM `fsm_busy`; acts as the fill request.
- `d_addr` in 16: D-cache fill FSM `memory_address`.
- `st_req` in 1: D-cache write-through store request. Held high until acknowledged.
- `st_addr` in 16: store address.
- `st_data` in 16: store data.
- `mem_valid_in` in 1: memory data-valid strobe.
- `mem_enable` out 1: memory access enable.
- `mem_wr` out 1: memory write enable.
- `mem_addr` out 16: memory address.
- `mem_wdata` out 16: memory write data.
- `i_data_valid` out 1: `mem_valid_in` gated to the I-cache.
- `d_data_valid` out 1: `mem_valid_in` gated to the D-cache.
- `waitForICACHE` out 1: tells the D-cache FSM to hold.
- `st_ack` out 1: one-cycle store acknowledge.
- `beat_count` out 4: valid beats received in the current grant.
- `arb_error` out 1: sticky watchdog flag.

## Operation
- The owner register holds one of IDLE, OWN_I, OWN_D or STORE.
- The grant decision is combinational while in IDLE, registered in the other states.
- Arbitration in IDLE (`owner_nxt`):
  - `st_req` has highest priority. Enter STORE.
  - Otherwise `i_busy` wins. Enter OWN_I.
  - Otherwise `d_busy`. Enter OWN_D.
  - Otherwise stay in IDLE.
- No preemption. OWN_I and OWN_D hold until the owner's busy drops; then return to IDLE.
- STORE lasts exactly one cycle:
  - `mem_enable`=1, `mem_wr`=1, `mem_addr`=`st_addr`, `mem_wdata`=`st_data`, `st_ack`=1.
  - Next state is IDLE.
- OWN_x, or the cycle where `owner_nxt`=OWN_x:
  - `mem_enable`=1, `mem_wr`=0, `mem_addr`=`x_addr`.
  - `x_data_valid`=`mem_valid_in`. The other requester's `data_valid` is 0.
- IDLE with no request: `mem_enable`=0, `mem_addr`=0, `mem_wdata`=0.
- `waitForICACHE` = `d_busy` & (`owner_nxt` != OWN_D). The D-cache FSM therefore stalls at word 0 until granted.
- `beat_count`:
  - Cleared on entry to any grant.
  - Increments on `mem_valid_in` while in OWN_I or OWN_D.
  - Saturates at 15.
- `mem_valid_in` arriving in IDLE or STORE is dropped. Neither requester's `data_valid` asserts.
- Reset mid-fill: owner goes to IDLE asynchronously, `beat_count` clears, all outputs are driven to 0. The requester re-arbitrates after reset deasserts.

## Timing
- Reset values: owner IDLE; all outputs 0; `arb_error` 0.
- Request to grant is 0 cycles. `mem_addr` reflects the winner in the same cycle the request first appears in IDLE.
- Release: busy low in cycle N gives IDLE in cycle N+1. A waiting requester is granted in N+1 (combinational decision). There is one dead cycle only if no request is pending.
- Simultaneous `i_busy` and `d_busy` in IDLE: I-cache is granted; `waitForICACHE`=1 that cycle.
- Simultaneous `st_req` and a fill request: STORE first. The fill is granted the following cycle.
- `st_req` arriving during a fill: not acknowledged until the fill releases and IDLE is reached.
- A store must not be issued while the same D-cache is mid-fill. This is the upstream requester's responsibility; the arbiter does not check it.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - A watchdog counter increments every cycle in OWN_I or OWN_D and clears on grant entry.
  - On reaching `TIMEOUT`: force IDLE next cycle, set `arb_error`.
  - `arb_error` is sticky until `rst`.
- Not defined: no counter; `arb_error` is tied to 0; grants are held indefinitely.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle → all outputs 0 immediately; owner is IDLE after release.
- Single I-fill:
  - Stimulus: `i_busy`=1, `i_addr`=0x1230; eight `mem_valid_in` beats; `i_busy` drops.
  - Required: `mem_addr`=0x1230 in the request cycle; `i_data_valid` mirrors each beat; `beat_count`=8; IDLE the next cycle.
- Collision:
  - Stimulus: `i_busy` and `d_busy` rise together.
  - Required: I granted and `waitForICACHE`=1 for the whole I-fill. D is granted in the cycle after `i_busy` drops, with `mem_addr`=`d_addr`.
- Store versus fill:
  - Stimulus: `st_req` (addr 0x0040, data 0xBEEF) together with `i_busy`.
  - Required: cycle 0 `mem_wr`=1, `mem_addr`=0x0040, `mem_wdata`=0xBEEF, `st_ack`=1. Cycle 1: OWN_I.
- Stray valid: `mem_valid_in`=1 in IDLE → `i_data_valid`=`d_data_valid`=0; `beat_count` unchanged.
- Watchdog (`ARB_TIMEOUT_EN`, `TIMEOUT`=16):
  - Stimulus: `d_busy` held high with no beats.
  - Required: after 16 cycles owner returns to IDLE and `arb_error`=1. With the macro undefined, OWN_D persists and `arb_error`=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester main-memory arbiter: I-cache fill, D-cache fill and D-cache write-through stores.
// Optional fill-grant watchdog enabled by defining ARB_TIMEOUT_EN.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_busy,
  input  logic [15:0] i_addr,
  input  logic        d_busy,
  input  logic [15:0] d_addr,
  input  logic        st_req,
  input  logic [15:0] st_addr,
  input  logic [15:0] st_data,
  input  logic        mem_valid_in,
  output logic        mem_enable,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        i_data_valid,
  output logic        d_data_valid,
  output logic        waitForICACHE,
  output logic        st_ack,
  output logic [3:0]  beat_count,
  output logic        arb_error
);

  localparam int unsigned BEAT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_I = 2'd1,
    OWN_D = 2'd2,
    STORE = 2'd3
  } owner_t;

  owner_t owner_q;
  owner_t owner_nxt;
  owner_t owner_d;
  logic   in_fill;
  logic   grant_entry;
  logic   timeout_hit;

  assign in_fill     = (owner_q == OWN_I) || (owner_q == OWN_D);
  assign grant_entry = (owner_q == IDLE) && (owner_nxt != IDLE);

  // Owner register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q <= IDLE;
    end else begin
      owner_q <= owner_d;
    end
  end

  // Grant: decided combinationally in IDLE, held by the register otherwise
  always_comb begin
    owner_nxt = owner_q;
    if (!rst && (owner_q == IDLE)) begin
      if (st_req) begin
        owner_nxt = STORE;
      end else if (i_busy) begin
        owner_nxt = OWN_I;
      end else if (d_busy) begin
        owner_nxt = OWN_D;
      end else begin
        owner_nxt = IDLE;
      end
    end
  end

  // Next owner: a fill persists while its busy is high; a store is a single cycle
  always_comb begin
    owner_d = IDLE;
    case (owner_nxt)
      OWN_I:   owner_d = i_busy ? OWN_I : IDLE;
      OWN_D:   owner_d = d_busy ? OWN_D : IDLE;
      default: owner_d = IDLE;
    endcase
    if (timeout_hit) begin
      owner_d = IDLE;
    end
  end

  // Memory request and beat steering follow the current grant
  always_comb begin
    mem_enable    = 1'b0;
    mem_wr        = 1'b0;
    mem_addr      = 16'h0000;
    mem_wdata     = 16'h0000;
    i_data_valid  = 1'b0;
    d_data_valid  = 1'b0;
    st_ack        = 1'b0;
    waitForICACHE = !rst && d_busy && (owner_nxt != OWN_D);
    case (owner_nxt)
      STORE: begin
        mem_enable = 1'b1;
        mem_wr     = 1'b1;
        mem_addr   = st_addr;
        mem_wdata  = st_data;
        st_ack     = 1'b1;
      end
      OWN_I: begin
        mem_enable   = 1'b1;
        mem_addr     = i_addr;
        i_data_valid = mem_valid_in;
      end
      OWN_D: begin
        mem_enable   = 1'b1;
        mem_addr     = d_addr;
        d_data_valid = mem_valid_in;
      end
      default: ;
    endcase
  end

  // Beats received in the current grant, saturating; stray beats in IDLE/STORE are dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_count <= '0;
    end else if (grant_entry) begin
      beat_count <= ((owner_nxt != STORE) && mem_valid_in) ? BEAT_W'(1) : '0;
    end else if (in_fill && mem_valid_in && (beat_count != {BEAT_W{1'b1}})) begin
      beat_count <= beat_count + BEAT_W'(1);
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [WD_W-1:0] wd_q;

  assign timeout_hit = in_fill && (wd_q == WD_W'(TIMEOUT - 1));

  // Watchdog on fill grants; the error flag is sticky until reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q      <= '0;
      arb_error <= 1'b0;
    end else begin
      if (grant_entry || !in_fill) begin
        wd_q <= '0;
      end else begin
        wd_q <= wd_q + WD_W'(1);
      end
      if (timeout_hit) begin
        arb_error <= 1'b1;
      end
    end
  end
`else
  logic unused_timeout;

  assign timeout_hit    = 1'b0;
  assign arb_error      = 1'b0;
  assign unused_timeout = (TIMEOUT == 0);
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: the driver queues hand-computed per-cycle outputs,
// a negedge monitor pops and compares them. Watchdog expectations follow ARB_TIMEOUT_EN.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_busy, d_busy, st_req, mem_valid_in;
  logic [15:0] i_addr, d_addr, st_addr, st_data;
  logic        mem_enable, mem_wr, i_data_valid, d_data_valid, waitForICACHE, st_ack, arb_error;
  logic [15:0] mem_addr, mem_wdata;
  logic [3:0]  beat_count;

  typedef struct {
    string       nm;
    logic        en, wr;
    logic [15:0] addr, wdata;
    logic        idv, ddv, wt, ack;
    logic [3:0]  bc;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  mem_arbiter #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .i_busy(i_busy), .i_addr(i_addr),
    .d_busy(d_busy), .d_addr(d_addr),
    .st_req(st_req), .st_addr(st_addr), .st_data(st_data),
    .mem_valid_in(mem_valid_in),
    .mem_enable(mem_enable), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .i_data_valid(i_data_valid), .d_data_valid(d_data_valid),
    .waitForICACHE(waitForICACHE), .st_ack(st_ack),
    .beat_count(beat_count), .arb_error(arb_error)
  );

  always #5 clk = ~clk;

  // Monitor: compare each cycle's outputs against the queued expectation
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (mem_enable !== e.en || mem_wr !== e.wr || mem_addr !== e.addr ||
          mem_wdata !== e.wdata || i_data_valid !== e.idv || d_data_valid !== e.ddv ||
          waitForICACHE !== e.wt || st_ack !== e.ack || beat_count !== e.bc ||
          arb_error !== e.err) begin
        errors++;
        $display("FAIL %s: got en=%b wr=%b addr=%h wdata=%h idv=%b ddv=%b wait=%b ack=%b bc=%0d err=%b | want en=%b wr=%b addr=%h wdata=%h idv=%b ddv=%b wait=%b ack=%b bc=%0d err=%b",
                 e.nm, mem_enable, mem_wr, mem_addr, mem_wdata, i_data_valid, d_data_valid,
                 waitForICACHE, st_ack, beat_count, arb_error,
                 e.en, e.wr, e.addr, e.wdata, e.idv, e.ddv, e.wt, e.ack, e.bc, e.err);
      end
    end
  end

  // Queue the expected outputs for the current input set, then advance one cycle
  task automatic expect_cyc(input string nm, input logic en, input logic wr,
                            input logic [15:0] addr, input logic [15:0] wdata,
                            input logic idv, input logic ddv, input logic wt, input logic ack,
                            input logic [3:0] bc, input logic err);
    exp_t e;
    e.nm = nm; e.en = en; e.wr = wr; e.addr = addr; e.wdata = wdata;
    e.idv = idv; e.ddv = ddv; e.wt = wt; e.ack = ack; e.bc = bc; e.err = err;
    sb.push_back(e);
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    i_busy = 1'b0; d_busy = 1'b0; st_req = 1'b0; mem_valid_in = 1'b0;
    i_addr = 16'h0; d_addr = 16'h0; st_addr = 16'h0; st_data = 16'h0;
    expect_cyc("reset", 0, 0, 16'h0, 16'h0, 0, 0, 0, 0, 4'd0, 0);
    rst = 1'b0;
    expect_cyc("idle_after_rst", 0, 0, 16'h0, 16'h0, 0, 0, 0, 0, 4'd0, 0);

    // Single I-fill with eight beats
    i_busy = 1'b1; i_addr = 16'h1230;
    expect_cyc("i_req", 1, 0, 16'h1230, 16'h0, 0, 0, 0, 0, 4'd0, 0);
    for (int k = 0; k < 8; k++) begin
      mem_valid_in = 1'b1;
      expect_cyc("i_beat", 1, 0, 16'h1230, 16'h0, 1, 0, 0, 0, 4'(k), 0);
      mem_valid_in = 1'b0;
      expect_cyc("i_gap", 1, 0, 16'h1230, 16'h0, 0, 0, 0, 0, 4'(k + 1), 0);
    end
    i_busy = 1'b0;
    expect_cyc("i_release", 1, 0, 16'h1230, 16'h0, 0, 0, 0, 0, 4'd8, 0);
    expect_cyc("i_idle", 0, 0, 16'h0, 16'h0, 0, 0, 0, 0, 4'd8, 0);

    // Stray valid in IDLE
    mem_valid_in = 1'b1;
    expect_cyc("stray", 0, 0, 16'h0, 16'h0, 0, 0, 0, 0, 4'd8, 0);
    mem_valid_in = 1'b0;
    expect_cyc("stray_after", 0, 0, 16'h0, 16'h0, 0, 0, 0, 0, 4'd8, 0);

    // Collision: I wins, D waits and is granted right after release
    i_busy = 1'b1; d_busy = 1'b1; i_addr = 16'h2000; d_addr = 16'h3000;
    expect_cyc("col_grant_i", 1, 0, 16'h2000, 16'h0, 0, 0, 1, 0, 4'd8, 0);
    expect_cyc("col_own_i", 1, 0, 16'h2000, 16'h0, 0, 0, 1, 0, 4'd0, 0);
    mem_valid_in = 1'b1;
    expect_cyc("col_i_beat", 1, 0, 16'h2000, 16'h0, 1, 0, 1, 0, 4'd0, 0);
    mem_valid_in = 1'b0;
    i_busy = 1'b0;
    expect_cyc("col_i_rel", 1, 0, 16'h2000, 16'h0, 0, 0, 1, 0, 4'd1, 0);
    expect_cyc("col_grant_d", 1, 0, 16'h3000, 16'h0, 0, 0, 0, 0, 4'd1, 0);
    mem_valid_in = 1'b1;
    expect_cyc("col_d_beat", 1, 0, 16'h3000, 16'h0, 0, 1, 0, 0, 4'd0, 0);
    mem_valid_in = 1'b0;
    d_busy = 1'b0;
    expect_cyc("col_d_rel", 1, 0, 16'h3000, 16'h0, 0, 0, 0, 0, 4'd1, 0);
    expect_cyc("col_idle", 0, 0, 16'h0, 16'h0, 0, 0, 0, 0, 4'd1, 0);

    // Store beats a simultaneous fill; a store during a fill waits for release
    st_req = 1'b1; st_addr = 16'h0040; st_data = 16'hBEEF; i_busy = 1'b1; i_addr = 16'h1230;
    expect_cyc("st_first", 1, 1, 16'h0040, 16'hBEEF, 0, 0, 0, 1, 4'd1, 0);
    st_req = 1'b0;
    expect_cyc("st_then_i", 1, 0, 16'h1230, 16'h0, 0, 0, 0, 0, 4'd0, 0);
    st_req = 1'b1; st_addr = 16'h0080; st_data = 16'h1234;
    expect_cyc("st_during_fill", 1, 0, 16'h1230, 16'h0, 0, 0, 0, 0, 4'd0, 0);
    i_busy = 1'b0;
    expect_cyc("st_fill_rel", 1, 0, 16'h1230, 16'h0, 0, 0, 0, 0, 4'd0, 0);
    expect_cyc("st_after_rel", 1, 1, 16'h0080, 16'h1234, 0, 0, 0, 1, 4'd0, 0);
    st_req = 1'b0;
    expect_cyc("st_idle", 0, 0, 16'h0, 16'h0, 0, 0, 0, 0, 4'd0, 0);

    // Reset mid-fill, then re-arbitration
    d_busy = 1'b1; d_addr = 16'h4444;
    expect_cyc("rf_grant", 1, 0, 16'h4444, 16'h0, 0, 0, 0, 0, 4'd0, 0);
    mem_valid_in = 1'b1;
    expect_cyc("rf_beat", 1, 0, 16'h4444, 16'h0, 0, 1, 0, 0, 4'd0, 0);
    mem_valid_in = 1'b0;
    expect_cyc("rf_gap", 1, 0, 16'h4444, 16'h0, 0, 0, 0, 0, 4'd1, 0);
    rst = 1'b1;
    expect_cyc("rf_rst", 0, 0, 16'h0, 16'h0, 0, 0, 0, 0, 4'd0, 0);
    expect_cyc("rf_rst_hold", 0, 0, 16'h0, 16'h0, 0, 0, 0, 0, 4'd0, 0);
    rst = 1'b0;
    expect_cyc("rf_rearb", 1, 0, 16'h4444, 16'h0, 0, 0, 0, 0, 4'd0, 0);
    d_busy = 1'b0;
    expect_cyc("rf_rel", 1, 0, 16'h4444, 16'h0, 0, 0, 0, 0, 4'd0, 0);
    expect_cyc("rf_idle", 0, 0, 16'h0, 16'h0, 0, 0, 0, 0, 4'd0, 0);

    // Watchdog: D held with no beats; an I request afterwards reveals whether IDLE was forced
    d_busy = 1'b1; d_addr = 16'h5000;
    expect_cyc("wd_grant", 1, 0, 16'h5000, 16'h0, 0, 0, 0, 0, 4'd0, 0);
    for (int k = 0; k < 16; k++) begin
      expect_cyc("wd_hold", 1, 0, 16'h5000, 16'h0, 0, 0, 0, 0, 4'd0, 0);
    end
    i_busy = 1'b1; i_addr = 16'h1230;
`ifdef ARB_TIMEOUT_EN
    expect_cyc("wd_forced_idle", 1, 0, 16'h1230, 16'h0, 0, 0, 1, 0, 4'd0, 1);
    i_busy = 1'b0; d_busy = 1'b0;
    expect_cyc("wd_rel", 1, 0, 16'h1230, 16'h0, 0, 0, 0, 0, 4'd0, 1);
    expect_cyc("wd_idle", 0, 0, 16'h0, 16'h0, 0, 0, 0, 0, 4'd0, 1);
`else
    expect_cyc("wd_persist", 1, 0, 16'h5000, 16'h0, 0, 0, 0, 0, 4'd0, 0);
    i_busy = 1'b0; d_busy = 1'b0;
    expect_cyc("wd_rel", 1, 0, 16'h5000, 16'h0, 0, 0, 0, 0, 4'd0, 0);
    expect_cyc("wd_idle", 0, 0, 16'h0, 16'h0, 0, 0, 0, 0, 4'd0, 0);
`endif
    rst = 1'b1;
    expect_cyc("err_clear", 0, 0, 16'h0, 16'h0, 0, 0, 0, 0, 4'd0, 0);
    rst = 1'b0;
    expect_cyc("final_idle", 0, 0, 16'h0, 16'h0, 0, 0, 0, 0, 4'd0, 0);

    // Every queued expectation must have been consumed by the monitor
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
